mux_select_sequencer: RTL and testbench

- Upstream control stage for the board's 5-to-1 3-bit switch multiplexer; generates the 3-bit select that feeds the mux's s2,s1,s0 inputs.
- Two ways to advance the select:
  - Manual: one step per debounced press of an active-low pushbutton.
  - Auto-scan: one step every SCAN_CYCLES clocks while a scan-enable switch is high.
- Select sequence is 0,1,2,3,4,0,… and addresses the inputs u,v,w,x,y respectively.

---
 rtl/mux_sel_pkg.sv | 26 ++
 rtl/mux_select_sequencer_if.sv | 35 +++
 rtl/mux_select_sequencer_key_debounce.sv | 61 ++++++
 rtl/mux_select_sequencer.sv | 79 +++++++
 tb/tb_mux_select_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared select encodings and helpers for the mux select sequencer
// Purpose : select width, default input count, select encodings and the wrap helper.
// Ports   : none (package).
package mux_sel_pkg;

   localparam int SEL_W_BITS      = 3;
   localparam int NUM_SEL_DEFAULT = 5;

   typedef logic [SEL_W_BITS-1:0] sel_t;

   // Mux input addressed by each select value.
   localparam sel_t SEL_U = 3'd0;
   localparam sel_t SEL_V = 3'd1;
   localparam sel_t SEL_W = 3'd2;
   localparam sel_t SEL_X = 3'd3;
   localparam sel_t SEL_Y = 3'd4;

   // Next select value; the last valid input wraps back to u.
   function automatic sel_t sel_next(input sel_t cur, input int unsigned num);
      if (32'(cur) + 32'd1 >= num) begin
         return SEL_U;
      end
      return cur + 3'd1;
   endfunction

endpackage

// File: rtl/mux_select_sequencer_if.sv
// rtl/mux_select_sequencer_if.sv - button/switch inputs and select outputs of the sequencer
// Purpose : bundles the raw board inputs and the sequencer outputs.
// Signals : STEP_N (raw active-low button), AUTO_EN (raw scan switch),
//           SEL (mux select), STEP_PULSE (accepted press), SCAN_TICK (scan period),
//           STEP_LEVEL (debounced button level, for observation).
// Modports: master = board/stimulus side, slave = sequencer side.
interface mux_select_sequencer_if;
   import mux_sel_pkg::*;

   logic STEP_N;
   logic AUTO_EN;
   sel_t SEL;
   logic STEP_PULSE;
   logic SCAN_TICK;
   logic STEP_LEVEL;

   modport master (
      output STEP_N,
      output AUTO_EN,
      input  SEL,
      input  STEP_PULSE,
      input  SCAN_TICK,
      input  STEP_LEVEL
   );

   modport slave (
      input  STEP_N,
      input  AUTO_EN,
      output SEL,
      output STEP_PULSE,
      output SCAN_TICK,
      output STEP_LEVEL
   );

endinterface

// File: rtl/mux_select_sequencer_key_debounce.sv
// rtl/mux_select_sequencer_key_debounce.sv - synchronizer, debouncer and press detector for one key
// Purpose : turns a raw bouncing active-low key into a clean level and a one-cycle press pulse.
// Ports   : CLOCK_50 (clock), RESET_N (async active-low reset), KEY_N (raw key, active-low),
//           LEVEL (debounced key level), PRESS_PULSE (registered pulse on debounced 1->0).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic KEY_N,
   output logic LEVEL,
   output logic PRESS_PULSE
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          key_meta_q;
   logic          key_s_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_prev_q;
   logic          pulse_q;

   // The counter only survives while the synchronized key disagrees with the
   // accepted level; any agreeing cycle restarts the qualification window.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (key_s_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = key_s_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         key_meta_q   <= 1'b1;
         key_s_q      <= 1'b1;
         level_q      <= 1'b1;
         cnt_q        <= '0;
         level_prev_q <= 1'b1;
         pulse_q      <= 1'b0;
      end else begin
         key_meta_q   <= KEY_N;
         key_s_q      <= key_meta_q;
         level_q      <= level_d;
         cnt_q        <= cnt_d;
         level_prev_q <= level_q;
         // Press only: release (0->1) and a held key produce nothing.
         pulse_q      <= level_prev_q & ~level_q;
      end
   end

   assign LEVEL       = level_q;
   assign PRESS_PULSE = pulse_q;

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - select generator for the 5-to-1 3-bit switch multiplexer
// Purpose : advances the mux select on debounced button presses and on auto-scan ticks.
// Ports   : CLOCK_50 (clock), RESET_N (async active-low reset),
//           bus (slave modport: STEP_N, AUTO_EN in; SEL, STEP_PULSE, SCAN_TICK, STEP_LEVEL out).
module mux_select_sequencer
   import mux_sel_pkg::*;
#(
   parameter int NUM_SEL         = NUM_SEL_DEFAULT,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SCAN_CYCLES     = 50000000
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   mux_select_sequencer_if.slave   bus
);

   localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_CYCLES - 1);

   logic          step_pulse;
   logic          auto_meta_q;
   logic          auto_s_q;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick_q, tick_d;
   sel_t          sel_q, sel_d;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_step_key (
      .CLOCK_50    (CLOCK_50),
      .RESET_N     (RESET_N),
      .KEY_N       (bus.STEP_N),
      .LEVEL       (bus.STEP_LEVEL),
      .PRESS_PULSE (step_pulse)
   );

   // Prescaler runs only while scan is enabled; disabling it discards the
   // partial period so a re-enable always waits a full period.
   always_comb begin
      pre_d  = '0;
      tick_d = 1'b0;
      if (auto_s_q) begin
         if (pre_q == PRE_LAST) begin
            tick_d = 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   // A press and a tick landing together still move the select by one.
   always_comb begin
      sel_d = sel_q;
      if (step_pulse || tick_q) begin
         sel_d = sel_next(sel_q, NUM_SEL);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         auto_meta_q <= 1'b0;
         auto_s_q    <= 1'b0;
         pre_q       <= '0;
         tick_q      <= 1'b0;
         sel_q       <= SEL_U;
      end else begin
         auto_meta_q <= bus.AUTO_EN;
         auto_s_q    <= auto_meta_q;
         pre_q       <= pre_d;
         tick_q      <= tick_d;
         sel_q       <= sel_d;
      end
   end

   assign bus.SEL        = sel_q;
   assign bus.STEP_PULSE = step_pulse;
   assign bus.SCAN_TICK  = tick_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - self-checking bench for mux_select_sequencer
module tb_mux_select_sequencer;

   localparam int D    = 4;
   localparam int S    = 8;
   localparam int NS   = 5;
   localparam int MAXE = 4096;

   logic clk;
   logic rst_n;

   mux_select_sequencer_if bus();

   mux_select_sequencer #(
      .NUM_SEL         (NS),
      .DEBOUNCE_CYCLES (D),
      .SCAN_CYCLES     (S)
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   // Reference model state, in terms of edges counted since reset release.
   int   n;
   logic raw_step [MAXE];
   logic raw_auto [MAXE];
   logic [2:0] sel_obs [MAXE];
   logic pulse_obs [MAXE];
   logic tick_obs [MAXE];
   int   m_sel;
   logic m_level;
   logic m_pulse;
   logic m_tick;
   logic fell_prev;
   int   last_flip;
   int   pulse_cnt;
   int   first_pulse_edge;
   int   tick_edges [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, n, obs, exp);
      end
   endtask

   // Key value seen by the debouncer at edge e: the raw value two edges earlier.
   function automatic logic s_at(input int e);
      if (e - 2 >= 1) return raw_step[e-2];
      return 1'b1;
   endfunction

   function automatic logic a_at(input int e);
      if (e - 2 >= 1) return raw_auto[e-2];
      return 1'b0;
   endfunction

   task automatic model_reset();
      n                = 0;
      m_sel            = 0;
      m_level          = 1'b1;
      m_pulse          = 1'b0;
      m_tick           = 1'b0;
      fell_prev        = 1'b0;
      last_flip        = 0;
      pulse_cnt        = 0;
      first_pulse_edge = -1;
      tick_edges.delete();
   endtask

   task automatic edge_step();
      logic all_diff;
      int   run;
      @(posedge clk);
      n++;
      if (n >= MAXE) begin
         $display("FAIL edge_budget edge=%0d observed=%0d expected<%0d", n, n, MAXE);
         $fatal(1, "edge budget exhausted");
      end
      raw_step[n] = bus.STEP_N;
      raw_auto[n] = bus.AUTO_EN;
      if (m_pulse || m_tick) m_sel = (m_sel + 1) % NS;
      m_pulse = fell_prev;
      fell_prev = 1'b0;
      // Level is accepted after D consecutive disagreeing edges since the last change.
      if (n - D >= last_flip) begin
         all_diff = 1'b1;
         for (int k = 0; k < D; k++) if (s_at(n - k) == m_level) all_diff = 1'b0;
         if (all_diff) begin
            m_level   = ~m_level;
            last_flip = n;
            fell_prev = (m_level == 1'b0);
         end
      end
      // Tick whenever the enabled run length reaches a whole number of periods.
      run = 0;
      for (int e = n; e >= 1; e--) begin
         if (a_at(e) != 1'b1) break;
         run++;
      end
      m_tick = (run > 0) && (run % S == 0);
      @(negedge clk);
      sel_obs[n]   = bus.SEL;
      pulse_obs[n] = bus.STEP_PULSE;
      tick_obs[n]  = bus.SCAN_TICK;
      if (bus.STEP_PULSE === 1'b1) begin
         pulse_cnt++;
         if (first_pulse_edge < 0) first_pulse_edge = n;
      end
      if (bus.SCAN_TICK === 1'b1) tick_edges.push_back(n);
      chk("sel", 32'(bus.SEL), 32'(m_sel));
      chk("step_pulse", 32'(bus.STEP_PULSE), 32'(m_pulse));
      chk("scan_tick", 32'(bus.SCAN_TICK), 32'(m_tick));
      chk("step_level", 32'(bus.STEP_LEVEL), 32'(m_level));
   endtask

   task automatic run_edges(input int k);
      for (int i = 0; i < k; i++) edge_step();
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.STEP_N  = 1'b1;
      bus.AUTO_EN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_sel", 32'(bus.SEL), 32'd0);
         chk("rst_pulse", 32'(bus.STEP_PULSE), 32'd0);
         chk("rst_tick", 32'(bus.SCAN_TICK), 32'd0);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic press(input int lo, input int hi);
      bus.STEP_N = 1'b0;
      run_edges(lo);
      bus.STEP_N = 1'b1;
      run_edges(hi);
   endtask

   function automatic int tick_at(input int idx);
      if (idx < tick_edges.size()) return tick_edges[idx];
      return -1;
   endfunction

   initial begin
      int wrap_exp [6];
      int a;
      checks   = 0;
      failures = 0;
      wrap_exp = '{1, 2, 3, 4, 0, 1};
      model_reset();

      // Reset, then a clean press and release.
      do_reset();
      bus.STEP_N = 1'b0;
      run_edges(20);
      chk("clean_pulse_count", 32'(pulse_cnt), 32'd1);
      chk("clean_pulse_edge", 32'(first_pulse_edge), 32'd7);
      chk("clean_sel_e7", 32'(sel_obs[7]), 32'd0);
      chk("clean_sel_e8", 32'(sel_obs[8]), 32'd1);
      bus.STEP_N = 1'b1;
      run_edges(12);
      chk("release_no_pulse", 32'(pulse_cnt), 32'd1);

      // Bounce: toggle every 2 cycles for 12 cycles, then held high.
      for (int i = 0; i < 6; i++) begin
         bus.STEP_N = i[0];
         run_edges(2);
      end
      bus.STEP_N = 1'b1;
      run_edges(10);
      chk("bounce_no_pulse", 32'(pulse_cnt), 32'd1);
      chk("bounce_sel", 32'(bus.SEL), 32'd1);
      press(15, 10);
      chk("bounce_then_hold", 32'(pulse_cnt), 32'd2);

      // Wrap through all inputs.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         press(10, 8);
         chk("wrap_sel", 32'(bus.SEL), 32'(wrap_exp[i]));
      end

      // Asynchronous reset between edges, button held across release.
      bus.STEP_N = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_sel", 32'(bus.SEL), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_edges(12);
      chk("held_after_rst_pulse_edge", 32'(first_pulse_edge), 32'd7);
      chk("held_after_rst_count", 32'(pulse_cnt), 32'd1);
      bus.STEP_N = 1'b1;
      run_edges(10);

      // Auto-scan from reset.
      do_reset();
      bus.AUTO_EN = 1'b1;
      run_edges(30);
      chk("scan_tick0", 32'(tick_at(0)), 32'd10);
      chk("scan_tick1", 32'(tick_at(1)), 32'd18);
      chk("scan_tick2", 32'(tick_at(2)), 32'd26);
      chk("scan_sel_e11", 32'(sel_obs[11]), 32'd1);
      chk("scan_sel_e19", 32'(sel_obs[19]), 32'd2);
      chk("scan_sel_e27", 32'(sel_obs[27]), 32'd3);
      bus.AUTO_EN = 1'b0;
      run_edges(20);
      chk("scan_off_ticks", 32'(tick_edges.size()), 32'd3);
      a = n;
      bus.AUTO_EN = 1'b1;
      run_edges(12);
      chk("scan_reenable_tick", 32'(tick_at(3)), 32'(a + 10));
      bus.AUTO_EN = 1'b0;
      run_edges(4);

      // Press pulse and scan tick in the same cycle with SEL at the last input.
      do_reset();
      for (int i = 0; i < 4; i++) press(10, 8);
      chk("collide_pre_sel", 32'(bus.SEL), 32'd4);
      a = n;
      bus.AUTO_EN = 1'b1;
      run_edges(3);
      bus.STEP_N = 1'b0;
      run_edges(7);
      chk("collide_pulse", 32'(pulse_obs[a+10]), 32'd1);
      chk("collide_tick", 32'(tick_obs[a+10]), 32'd1);
      run_edges(1);
      chk("collide_sel", 32'(bus.SEL), 32'd0);
      bus.AUTO_EN = 1'b0;
      bus.STEP_N  = 1'b1;
      run_edges(10);

      // Randomized bursts against the model.
      for (int b = 0; b < 90; b++) begin
         bus.STEP_N = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) bus.AUTO_EN = ~bus.AUTO_EN;
         run_edges(int'($urandom_range(1, 8)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
